// File: rtl/cache_reg_xfer_if.sv
// Bus bundle for cache_reg_xfer: command handshake, cache four-phase port,
// register-file four-phase port and the completion/abort pulses.
//
// Parameters: N (data width), ADDR_W (cache address width).
// Modports:
//   slave  - the transfer engine (accepts commands, drives both req ports)
//   master - the command issuer and the two responders around the engine
interface cache_reg_xfer_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 12
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [ADDR_W-1:0] cmd_caddr;
  logic [3:0]        cmd_raddr;
  // cache side
  logic              cache_req;
  logic              cache_ack;
  logic              cache_we;
  logic              cache_re;
  logic [ADDR_W-1:0] cache_addr;
  logic [N-1:0]      cache_wdata;
  logic [N-1:0]      cache_rdata;
  // register-file side
  logic              reg_req;
  logic              reg_ack;
  logic              reg_we;
  logic              reg_re;
  logic [3:0]        reg_addr;
  logic [N-1:0]      reg_wdata;
  logic [N-1:0]      reg_rdata;
  // status pulses
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_caddr, cmd_raddr,
    input  cache_ack, cache_rdata, reg_ack, reg_rdata,
    output cmd_ready,
    output cache_req, cache_we, cache_re, cache_addr, cache_wdata,
    output reg_req, reg_we, reg_re, reg_addr, reg_wdata,
    output done, err
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_caddr, cmd_raddr,
    output cache_ack, cache_rdata, reg_ack, reg_rdata,
    input  cmd_ready,
    input  cache_req, cache_we, cache_re, cache_addr, cache_wdata,
    input  reg_req, reg_we, reg_re, reg_addr, reg_wdata,
    input  done, err
  );
endinterface

// File: rtl/cache_reg_xfer.sv
// cache_reg_xfer: moves one N-bit word between a cache and a 16-entry
// register file using a four-phase req/ack handshake on each side.
// A load reads the cache and writes the register file; a store reads the
// register file and writes the cache. Both acks arrive asynchronously and
// are resynchronised with two flops before the FSM looks at them.
//
// Parameters: N (data width), ADDR_W (cache address width),
//             TIMEOUT (max cycles spent in any one wait state).
// Ports:      clk   - rising-edge clock
//             rst_n - synchronous active-low reset
//             bus   - cache_reg_xfer_if.slave (command, cache, reg file,
//                     done/err pulses)
// Build option: define XFER_TIMEOUT_EN to add the per-state wait counter
//             that aborts a stalled transfer with an err pulse. Without it
//             err is tied low and waits are unbounded.
module cache_reg_xfer #(
  parameter int N       = 32,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  cache_reg_xfer_if.slave bus
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("cache_reg_xfer: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S1_REQ = 3'd1,
    S1_REL = 3'd2,
    S2_REQ = 3'd3,
    S2_REL = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_adv;   // where the handshake alone would go
  state_t            state_next;  // after a possible timeout abort
  logic              expired;

  logic [1:0]        cache_sync;
  logic [1:0]        reg_sync;
  logic              cache_ack_s;
  logic              reg_ack_s;
  logic              side1_ack_s;
  logic              side2_ack_s;

  logic              dir_q;
  logic [ADDR_W-1:0] caddr_q;
  logic [3:0]        raddr_q;
  logic [N-1:0]      xfer_buf;

  // ack synchronisers: the FSM only ever looks at the second stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_sync <= '0;
      reg_sync   <= '0;
    end else begin
      cache_sync <= {cache_sync[0], bus.cache_ack};
      reg_sync   <= {reg_sync[0], bus.reg_ack};
    end
  end

  assign cache_ack_s = cache_sync[1];
  assign reg_ack_s   = reg_sync[1];

  // side 1 is the source (read), side 2 the destination (write)
  assign side1_ack_s = dir_q ? reg_ack_s : cache_ack_s;
  assign side2_ack_s = dir_q ? cache_ack_s : reg_ack_s;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

`ifdef XFER_TIMEOUT_EN
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             wait_st;
  logic             err_q;

  assign wait_st = (state == S1_REQ) || (state == S1_REL) ||
                   (state == S2_REQ) || (state == S2_REL);
`endif

  // next-state logic
  always_comb begin
    state_adv = state;
    case (state)
      IDLE:    if (bus.cmd_valid)  state_adv = S1_REQ;
      S1_REQ:  if (side1_ack_s)    state_adv = S1_REL;
      S1_REL:  if (!side1_ack_s)   state_adv = S2_REQ;
      S2_REQ:  if (side2_ack_s)    state_adv = S2_REL;
      S2_REL:  if (!side2_ack_s)   state_adv = DONE;
      DONE:                        state_adv = IDLE;
      default:                     state_adv = IDLE;
    endcase
    expired = 1'b0;
`ifdef XFER_TIMEOUT_EN
    // a handshake that completes on the last allowed cycle still wins
    expired = wait_st && (state_adv == state) && (tmo_cnt == CNT_LAST);
`endif
    state_next = expired ? IDLE : state_adv;
  end

  // output logic: only the side owning the current phase is ever driven
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.cache_req = 1'b0;
    bus.cache_re  = 1'b0;
    bus.cache_we  = 1'b0;
    bus.reg_req   = 1'b0;
    bus.reg_re    = 1'b0;
    bus.reg_we    = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: bus.cmd_ready = 1'b1;
      S1_REQ: begin
        if (dir_q) begin
          bus.reg_req = 1'b1;
          bus.reg_re  = 1'b1;
        end else begin
          bus.cache_req = 1'b1;
          bus.cache_re  = 1'b1;
        end
      end
      S2_REQ: begin
        if (dir_q) begin
          bus.cache_req = 1'b1;
          bus.cache_we  = 1'b1;
        end else begin
          bus.reg_req = 1'b1;
          bus.reg_we  = 1'b1;
        end
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // command latch and transfer buffer; fields are only sampled in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q    <= 1'b0;
      caddr_q  <= '0;
      raddr_q  <= '0;
      xfer_buf <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        dir_q   <= bus.cmd_dir;
        caddr_q <= bus.cmd_caddr;
        raddr_q <= bus.cmd_raddr;
      end
      if (state == S1_REQ && state_next == S1_REL)
        xfer_buf <= dir_q ? bus.reg_rdata : bus.cache_rdata;
    end
  end

  // addresses and write data stay put through every phase of a transfer;
  // only the side whose we is high actually consumes its wdata
  assign bus.cache_addr  = caddr_q;
  assign bus.reg_addr    = raddr_q;
  assign bus.cache_wdata = xfer_buf;
  assign bus.reg_wdata   = xfer_buf;

`ifdef XFER_TIMEOUT_EN
  // wait counter restarts on every state entry; err is registered so it
  // lands in the first IDLE cycle after the abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= expired;
      if (!wait_st || (state_next != state)) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_reg_xfer.sv
`timescale 1ns/1ps
module tb_cache_reg_xfer;
  localparam int N      = 32;
  localparam int ADDR_W = 12;
  localparam int TMO    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_reg_xfer_if #(.N(N), .ADDR_W(ADDR_W)) bus ();
  cache_reg_xfer #(.N(N), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- responders: memories plus ack generation ----------------
  logic [N-1:0] cmem [4096];
  bit           cvld [4096];
  logic [N-1:0] rmem [16];
  bit           rvld [16];
  bit comb_mode;            // 1: ack = req combinationally, 0: random delays
  bit c_hold0, r_hold0;     // force an ack low
  bit c_ack_r, r_ack_r;
  int c_dly, r_dly;

  function automatic logic [N-1:0] init_c(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h0100_0193) ^ 32'h0000_0002;
  endfunction
  function automatic logic [N-1:0] init_r(input logic [3:0] i);
    return (i == 4'd2) ? 32'hDEAD_BEEF : (32'(i) * 32'h1357_9BDF) + 32'hA5A5_0000;
  endfunction
  function automatic logic [N-1:0] c_peek(input logic [ADDR_W-1:0] a);
    return cvld[a] ? cmem[a] : init_c(a);
  endfunction
  function automatic logic [N-1:0] r_peek(input logic [3:0] i);
    return rvld[i] ? rmem[i] : init_r(i);
  endfunction

  assign bus.cache_rdata = cvld[bus.cache_addr] ? cmem[bus.cache_addr] : init_c(bus.cache_addr);
  assign bus.reg_rdata   = rvld[bus.reg_addr] ? rmem[bus.reg_addr] : init_r(bus.reg_addr);
  assign bus.cache_ack   = c_hold0 ? 1'b0 : (comb_mode ? bus.cache_req : c_ack_r);
  assign bus.reg_ack     = r_hold0 ? 1'b0 : (comb_mode ? bus.reg_req : r_ack_r);

  always @(posedge clk) begin
    if (!comb_mode) begin
      if (bus.cache_req != c_ack_r) begin
        if (c_dly == 0) begin c_ack_r <= bus.cache_req; c_dly <= $urandom_range(0, 2); end
        else c_dly <= c_dly - 1;
      end
      if (bus.reg_req != r_ack_r) begin
        if (r_dly == 0) begin r_ack_r <= bus.reg_req; r_dly <= $urandom_range(0, 2); end
        else r_dly <= r_dly - 1;
      end
    end
    if (bus.cache_req && bus.cache_we) begin
      cmem[bus.cache_addr] <= bus.cache_wdata;
      cvld[bus.cache_addr] <= 1'b1;
    end
    if (bus.reg_req && bus.reg_we) begin
      rmem[bus.reg_addr] <= bus.reg_wdata;
      rvld[bus.reg_addr] <= 1'b1;
    end
  end

  // ---------------- reference model: architectural contents ----------------
  logic [N-1:0] mc [4096];
  logic [N-1:0] mr [16];

  // ---------------- transaction driver + observations ----------------
  int o_done_e, o_done_cnt, o_err_cnt, o_ready_busy, o_bad_side;
  int o_addr_bad, o_wdata_bad, o_s1_e, o_s2_e, o_post_req;
  bit o_tmo;

  task automatic run_xfer(input bit dir, input logic [ADDR_W-1:0] caddr,
                          input logic [3:0] raddr, input logic [N-1:0] data,
                          input bit poke);
    int w;
    bit s1, s2, other;
    o_done_e = -1; o_done_cnt = 0; o_err_cnt = 0; o_ready_busy = 0; o_bad_side = 0;
    o_addr_bad = 0; o_wdata_bad = 0; o_s1_e = -1; o_s2_e = -1; o_post_req = 0; o_tmo = 0;
    w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.cmd_ready) begin o_tmo = 1; return; end
    bus.cmd_valid = 1'b1; bus.cmd_dir = dir; bus.cmd_caddr = caddr; bus.cmd_raddr = raddr;
    @(posedge clk); #1;
    bus.cmd_valid = poke;
    if (poke) begin bus.cmd_dir = ~dir; bus.cmd_caddr = ~caddr; bus.cmd_raddr = ~raddr; end
    for (int e = 0; e < 300; e++) begin
      @(negedge clk);
      if (poke && e == 6) bus.cmd_valid = 1'b0;
      s1    = dir ? bus.reg_re : bus.cache_re;
      s2    = dir ? bus.cache_we : bus.reg_we;
      other = dir ? (bus.reg_we | bus.cache_re) : (bus.cache_we | bus.reg_re);
      if (other || (bus.cache_req != (bus.cache_re | bus.cache_we)) ||
          (bus.reg_req != (bus.reg_re | bus.reg_we))) o_bad_side++;
      if (o_done_e < 0) begin
        if (bus.cmd_ready) o_ready_busy++;
        if (bus.cache_addr !== caddr || bus.reg_addr !== raddr) o_addr_bad++;
        if (s1 && o_s1_e < 0) o_s1_e = e;
        if (s2 && o_s2_e < 0) o_s2_e = e;
        if (s2 && ((dir ? bus.cache_wdata : bus.reg_wdata) !== data)) o_wdata_bad++;
      end else if (bus.cache_req || bus.reg_req) o_post_req++;
      if (bus.done) begin o_done_cnt++; if (o_done_e < 0) o_done_e = e; end
      if (bus.err) o_err_cnt++;
      if (o_done_e >= 0 && e >= o_done_e + 3) break;
    end
    if (o_done_e < 0) o_tmo = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_caddr = '0; bus.cmd_raddr = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.cache_req !== 1'b0) begin tests_failed++; $display("FAIL reset_cache_req: got %b want 0", bus.cache_req); end
    tests_run++; if (bus.reg_req !== 1'b0) begin tests_failed++; $display("FAIL reset_reg_req: got %b want 0", bus.reg_req); end
    tests_run++; if ({bus.cache_re, bus.cache_we, bus.reg_re, bus.reg_we} !== 4'b0) begin tests_failed++; $display("FAIL reset_strobes: got %b want 0000", {bus.cache_re, bus.cache_we, bus.reg_re, bus.reg_we}); end
    tests_run++; if ({bus.done, bus.err} !== 2'b00) begin tests_failed++; $display("FAIL reset_done_err: got %b want 00", {bus.done, bus.err}); end
    tests_run++; if (bus.cache_addr !== '0 || bus.reg_addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got %h/%h want 0/0", bus.cache_addr, bus.reg_addr); end
    tests_run++; if (bus.cache_wdata !== '0 || bus.reg_wdata !== '0) begin tests_failed++; $display("FAIL reset_wdata: got %h/%h want 0/0", bus.cache_wdata, bus.reg_wdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_load;
    logic [N-1:0] exp;
    comb_mode = 1'b1;
    exp = mc[0];
    run_xfer(1'b0, 12'h000, 4'd0, exp, 1'b0);
    mr[0] = exp;
    tests_run++; if (o_tmo || o_done_cnt != 1) begin tests_failed++; $display("FAIL load_done: got %0d pulses (timeout %0d) want 1", o_done_cnt, o_tmo); end
    tests_run++; if (o_s1_e != 0 || o_s2_e != 6) begin tests_failed++; $display("FAIL load_order: got re@%0d we@%0d want re@0 we@6", o_s1_e, o_s2_e); end
    tests_run++; if (o_wdata_bad != 0 || o_addr_bad != 0 || o_bad_side != 0) begin tests_failed++; $display("FAIL load_bus: got wdata_bad=%0d addr_bad=%0d side_bad=%0d want 0", o_wdata_bad, o_addr_bad, o_bad_side); end
    tests_run++; if (r_peek(4'd0) !== 32'h0000_0002) begin tests_failed++; $display("FAIL load_result: got %h want 00000002", r_peek(4'd0)); end
    tests_run++; if (o_err_cnt != 0) begin tests_failed++; $display("FAIL load_err: got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_store;
    logic [N-1:0] exp;
    comb_mode = 1'b1;
    exp = mr[2];
    run_xfer(1'b1, 12'h002, 4'd2, exp, 1'b0);
    mc[2] = exp;
    tests_run++; if (o_tmo || o_done_cnt != 1) begin tests_failed++; $display("FAIL store_done: got %0d pulses (timeout %0d) want 1", o_done_cnt, o_tmo); end
    tests_run++; if (o_s1_e != 0 || o_s2_e != 6) begin tests_failed++; $display("FAIL store_order: got re@%0d we@%0d want re@0 we@6", o_s1_e, o_s2_e); end
    tests_run++; if (o_wdata_bad != 0 || o_addr_bad != 0 || o_bad_side != 0) begin tests_failed++; $display("FAIL store_bus: got wdata_bad=%0d addr_bad=%0d side_bad=%0d want 0", o_wdata_bad, o_addr_bad, o_bad_side); end
    tests_run++; if (c_peek(12'h002) !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL store_result: got %h want deadbeef", c_peek(12'h002)); end
  endtask

  task automatic test_latency;
    bit d;
    logic [ADDR_W-1:0] ca;
    logic [3:0] ra;
    logic [N-1:0] exp;
    comb_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 1'($urandom_range(0, 1)); ca = 12'($urandom_range(0, 4095)); ra = 4'($urandom_range(0, 15));
      exp = d ? mr[ra] : mc[ca];
      run_xfer(d, ca, ra, exp, 1'b0);
      if (d) mc[ca] = exp; else mr[ra] = exp;
      tests_run++; if (o_done_e != 12) begin tests_failed++; $display("FAIL latency_done_edge: got %0d want 12", o_done_e); end
      tests_run++; if (o_ready_busy != 0) begin tests_failed++; $display("FAIL latency_ready_busy: got %0d cycles want 0", o_ready_busy); end
    end
  endtask

  task automatic test_busy;
    logic [N-1:0] exp;
    comb_mode = 1'b1;
    exp = mc[12'h0A5];
    run_xfer(1'b0, 12'h0A5, 4'd9, exp, 1'b1);
    mr[9] = exp;
    tests_run++; if (o_addr_bad != 0) begin tests_failed++; $display("FAIL busy_addr: got %0d disturbed cycles want 0", o_addr_bad); end
    tests_run++; if (o_done_cnt != 1 || o_post_req != 0) begin tests_failed++; $display("FAIL busy_ignore: got done=%0d post_req=%0d want 1/0", o_done_cnt, o_post_req); end
    tests_run++; if (r_peek(4'd9) !== exp || o_wdata_bad != 0) begin tests_failed++; $display("FAIL busy_result: got %h want %h", r_peek(4'd9), exp); end
  endtask

  task automatic test_random;
    bit d;
    logic [ADDR_W-1:0] ca;
    logic [3:0] ra;
    logic [N-1:0] exp;
    comb_mode = 1'b0;
    for (int k = 0; k < 24; k++) begin
      d = 1'($urandom_range(0, 1)); ca = 12'($urandom_range(0, 15)); ra = 4'($urandom_range(0, 15));
      exp = d ? mr[ra] : mc[ca];
      run_xfer(d, ca, ra, exp, 1'b0);
      if (d) mc[ca] = exp; else mr[ra] = exp;
      tests_run++; if (o_tmo || o_done_cnt != 1 || o_err_cnt != 0) begin tests_failed++; $display("FAIL random_done[%0d]: got done=%0d err=%0d timeout=%0d want 1/0/0", k, o_done_cnt, o_err_cnt, o_tmo); end
      tests_run++; if (o_wdata_bad != 0 || o_bad_side != 0 || o_addr_bad != 0) begin tests_failed++; $display("FAIL random_bus[%0d]: got wdata_bad=%0d side_bad=%0d addr_bad=%0d want 0", k, o_wdata_bad, o_bad_side, o_addr_bad); end
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++; if (r_peek(4'(i)) !== mr[i]) begin tests_failed++; $display("FAIL random_reg[%0d]: got %h want %h", i, r_peek(4'(i)), mr[i]); end
      tests_run++; if (c_peek(12'(i)) !== mc[i]) begin tests_failed++; $display("FAIL random_cache[%0d]: got %h want %h", i, c_peek(12'(i)), mc[i]); end
    end
    comb_mode = 1'b1;
  endtask

  task automatic test_reset_mid;
    int dn, er;
    comb_mode = 1'b1;
    dn = 0; er = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_caddr = 12'h005; bus.cmd_raddr = 4'd3;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (7) begin @(negedge clk); dn += int'(bus.done); er += int'(bus.err); end
    tests_run++; if (bus.reg_req !== 1'b1 || bus.reg_we !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_s2: got req=%b we=%b want 1/1", bus.reg_req, bus.reg_we); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++; if ({bus.cache_req, bus.reg_req, bus.cache_re, bus.cache_we, bus.reg_re, bus.reg_we} !== 6'b0) begin tests_failed++; $display("FAIL rstmid_outputs: got %b want 000000", {bus.cache_req, bus.reg_req, bus.cache_re, bus.cache_we, bus.reg_re, bus.reg_we}); end
    tests_run++; if (bus.cache_addr !== '0 || bus.reg_wdata !== '0) begin tests_failed++; $display("FAIL rstmid_cleared: got addr=%h wdata=%h want 0/0", bus.cache_addr, bus.reg_wdata); end
    // the destination saw one write strobe before the reset edge
    mr[3] = mc[5];
    @(negedge clk);
    dn += int'(bus.done); er += int'(bus.err);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b want 1", bus.cmd_ready); end
    repeat (15) begin @(negedge clk); dn += int'(bus.done); er += int'(bus.err); end
    tests_run++; if (dn != 0 || er != 0) begin tests_failed++; $display("FAIL rstmid_pulses: got done=%0d err=%0d want 0/0", dn, er); end
    tests_run++; if (r_peek(4'd3) !== mr[3]) begin tests_failed++; $display("FAIL rstmid_partial: got %h want %h", r_peek(4'd3), mr[3]); end
  endtask

  task automatic test_timeout;
    int err_e, err_n, dn, req_cnt;
    bit req_at_err, rdy_at_err;
    comb_mode = 1'b1;
    c_hold0 = 1'b1;
    err_e = -1; err_n = 0; dn = 0; req_cnt = 0; req_at_err = 1'b1; rdy_at_err = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_caddr = 12'h007; bus.cmd_raddr = 4'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (bus.cache_req) req_cnt++;
      if (bus.done) dn++;
      if (bus.err) begin
        err_n++;
        if (err_e < 0) begin err_e = e; req_at_err = bus.cache_req; rdy_at_err = bus.cmd_ready; end
      end
    end
`ifdef XFER_TIMEOUT_EN
    tests_run++; if (err_e != TMO || err_n != 1) begin tests_failed++; $display("FAIL timeout_err: got first@%0d count=%0d want @%0d count=1", err_e, err_n, TMO); end
    tests_run++; if (req_at_err !== 1'b0 || rdy_at_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_state: got req=%b ready=%b want 0/1", req_at_err, rdy_at_err); end
    tests_run++; if (dn != 0 || req_cnt != TMO) begin tests_failed++; $display("FAIL timeout_done: got done=%0d req_cycles=%0d want 0/%0d", dn, req_cnt, TMO); end
    c_hold0 = 1'b0;
`else
    tests_run++; if (err_n != 0 || req_cnt != 40 || dn != 0) begin tests_failed++; $display("FAIL nowait_limit: got err=%0d req_cycles=%0d done=%0d want 0/40/0", err_n, req_cnt, dn); end
    c_hold0 = 1'b0;
    mr[1] = mc[7];
    for (int e = 0; e < 50 && dn == 0; e++) begin @(negedge clk); if (bus.done) dn++; end
    tests_run++; if (dn != 1 || r_peek(4'd1) !== mr[1]) begin tests_failed++; $display("FAIL nowait_resume: got done=%0d data=%h want 1/%h", dn, r_peek(4'd1), mr[1]); end
`endif
  endtask

  initial begin
    comb_mode = 1'b1; c_hold0 = 1'b0; r_hold0 = 1'b0;
    for (int i = 0; i < 4096; i++) mc[i] = init_c(12'(i));
    for (int i = 0; i < 16; i++) mr[i] = init_r(4'(i));
    test_reset();
    test_load();
    test_store();
    test_latency();
    test_busy();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1);
  end
endmodule

// File: doc/cache_reg_xfer.md
CACHE_REG_XFER -- requirements
Module: cache_reg_xfer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter N, default 32, SHALL be the data width.
REQ-003 Parameter ADDR_W, default 12, SHALL be the cache address width.
REQ-004 Parameter TIMEOUT, default 255, SHALL be the maximum wait cycles per handshake phase.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst_n, input, 1: synchronous active-low reset.
REQ-007 Ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-008 Port cmd_dir, input, 1: 0 = load (cache to reg), 1 = store (reg to cache).
REQ-009 Ports cmd_caddr (input, ADDR_W) and cmd_raddr (input, 4): transfer addresses.
REQ-010 Ports cache_req (output, 1) and cache_ack (input, 1, asynchronous): cache four-phase handshake.
REQ-011 Cache command ports SHALL be cache_we (output, 1), cache_re (output, 1), cache_addr (output, ADDR_W), cache_wdata (output, N) and cache_rdata (input, N).
REQ-012 Ports reg_req (output, 1) and reg_ack (input, 1, asynchronous): register-file four-phase handshake.
REQ-013 Register-file command ports SHALL be reg_we (output, 1), reg_re (output, 1), reg_addr (output, 4), reg_wdata (output, N) and reg_rdata (input, N).
REQ-014 Ports done (output, 1) and err (output, 1) SHALL be single-cycle completion and abort pulses.

Function
REQ-015 Each of cache_ack and reg_ack SHALL pass through a two-flop synchronizer; the FSM SHALL act only on the second-stage outputs ack_s.
REQ-016 The FSM SHALL have the states IDLE, S1_REQ, S1_REL, S2_REQ, S2_REL and DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 When cmd_valid and cmd_ready are both 1 at a rising edge, the block SHALL latch dir and both addresses and enter S1_REQ.
REQ-019 Side 1 SHALL be the cache (re) for a load and the register file (re) for a store.
REQ-020 Side 2 SHALL be the register file (we) for a load and the cache (we) for a store.
REQ-021 In S*_REQ, the active side's req and its re or we SHALL be 1, with address and wdata stable; the FSM SHALL leave to S*_REL at the first edge where that side's ack_s is 1.
REQ-022 On the edge leaving S1_REQ, the block SHALL capture the side-1 rdata into an N-bit buffer, which then drives side-2 wdata.
REQ-023 In S*_REL, req, re and we SHALL be 0 and address and wdata SHALL be held.
REQ-024 S1_REL SHALL go to S2_REQ, and S2_REL to DONE, at the first edge where ack_s is 0.
REQ-025 In DONE, done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-026 The inactive side's req, re and we SHALL be 0 at all times.
REQ-027 With a responder whose ack follows req combinationally, each phase SHALL take exactly 3 cycles, and done SHALL be high in the cycle after the 12th edge following the accept edge.
REQ-028 cmd_valid while busy SHALL be ignored, and the command fields SHALL NOT be sampled.
REQ-029 An ack that is already 1 on entry to S*_REQ SHALL be honoured as an acknowledge; an ack that drops before the FSM observes it high SHALL be ignored.

Reset
REQ-030 While rst_n is 0 at an edge, the state SHALL go to IDLE and cache_req, reg_req, we, re, done and err SHALL go to 0.
REQ-031 While rst_n is 0 at an edge, cache_addr, cache_wdata, reg_addr, reg_wdata, the buffer and both synchronizers SHALL be cleared to 0.
REQ-032 cmd_ready SHALL be 1 in the first cycle after rst_n rises.
REQ-033 A reset mid-transfer SHALL abandon the transfer without pulsing done or err.

Configuration
REQ-034 With XFER_TIMEOUT_EN defined, a per-phase counter SHALL clear on every state entry.
REQ-035 With XFER_TIMEOUT_EN defined, if a wait state persists for TIMEOUT cycles, the block SHALL drop all req, re and we, pulse err for one cycle, and go to IDLE without pulsing done.
REQ-036 Without XFER_TIMEOUT_EN, there SHALL be no counter, err SHALL be tied to 0, and waits SHALL be unbounded.

Verification
REQ-037 Load test: cache holds 0x2 at 0x000; issue load caddr=0x000, raddr=0 -> cache_re pulse with cache_addr=0x000, then reg_we with reg_wdata=0x2 and reg_addr=0, then done=1 once.
REQ-038 Store test: reg 2 holds 0xDEADBEEF; issue store raddr=2, caddr=0x002 -> reg_re, then cache_we with cache_wdata=0xDEADBEEF and cache_addr=0x002, then done.
REQ-039 Latency test: zero-delay responders -> done high in the cycle after the 12th edge after the accept edge; cmd_ready=0 throughout the transfer.
REQ-040 Busy test: a second cmd_valid with different addresses during a transfer -> ignored; the first transfer's addresses stay unchanged until done.
REQ-041 Reset test: rst_n=0 while in S2_REQ -> req, we and re are 0 after the edge, done and err are never pulsed, and cmd_ready=1 after release.
REQ-042 Timeout test: with XFER_TIMEOUT_EN and TIMEOUT=8, cache_ack held 0 -> err pulses after 8 cycles in S1_REQ, cache_req=0, and cmd_ready=1.
